// File: rtl/maze_walker.sv
// maze_walker: depth-first search over a one-bit-per-cell maze memory, with a
// move-history stack for backtracking and valid/ready replay of the found path.
module maze_walker #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int ADDR_W = 4,
  parameter int ADDR_H = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     mem_wr,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr_x,
  output logic [ADDR_H-1:0]        mem_addr_y,
  output logic                     mem_wdata,
  input  logic                     mem_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [ADDR_W+ADDR_H-1:0] path_len,
  output logic                     move_valid,
  output logic [1:0]               move_dir,
  input  logic                     move_ready
);

  localparam int PW    = ADDR_W + ADDR_H;
  localparam int DEPTH = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_H-1:0] Y_MAX = ADDR_H'(HEIGHT - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CHK     = 4'd1,
    S_CHK_W   = 4'd2,
    S_MARK    = 4'd3,
    S_PROBE   = 4'd4,
    S_PROBE_W = 4'd5,
    S_BACK    = 4'd6,
    S_REPLAY  = 4'd7,
    S_DONE    = 4'd8,
    S_FAIL    = 4'd9
  } state_t;

  function automatic logic in_bounds(input logic [ADDR_W-1:0] x,
                                     input logic [ADDR_H-1:0] y,
                                     input logic [1:0]        d);
    case (d)
      2'd0:    in_bounds = (y != '0);
      2'd1:    in_bounds = (x != X_MAX);
      2'd2:    in_bounds = (y != Y_MAX);
      default: in_bounds = (x != '0);
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] step_x(input logic [ADDR_W-1:0] x,
                                               input logic [1:0]        d);
    case (d)
      2'd1:    step_x = x + ADDR_W'(1);
      2'd3:    step_x = x - ADDR_W'(1);
      default: step_x = x;
    endcase
  endfunction

  function automatic logic [ADDR_H-1:0] step_y(input logic [ADDR_H-1:0] y,
                                               input logic [1:0]        d);
    case (d)
      2'd0:    step_y = y - ADDR_H'(1);
      2'd2:    step_y = y + ADDR_H'(1);
      default: step_y = y;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_x_q, cur_x_d;
  logic [ADDR_H-1:0] cur_y_q, cur_y_d;
  logic [1:0]        dir_q, dir_d;
  logic [PW-1:0]     sp_q, sp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic [1:0]        stack_q [DEPTH];

  logic              mem_wr_q, mem_wr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] addr_x_q, addr_x_d;
  logic [ADDR_H-1:0] addr_y_q, addr_y_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              move_valid_q, move_valid_d;
  logic [1:0]        move_dir_q, move_dir_d;

  logic              push_en;
  logic [PW-1:0]     sp_m1;
  logic [1:0]        top_dir;
  logic              cand_ok;
  logic [ADDR_W-1:0] cand_x;
  logic [ADDR_H-1:0] cand_y;
  logic              nxt_ok;
  logic              at_goal;

  // Next-state search logic followed by the next values of all registered outputs.
  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    dir_d   = dir_q;
    sp_d    = sp_q;
    rp_d    = rp_q;
    push_en = 1'b0;
    sp_m1   = sp_q - PW'(1);
    top_dir = stack_q[sp_m1];
    cand_ok = in_bounds(cur_x_q, cur_y_q, dir_q);
    cand_x  = step_x(cur_x_q, dir_q);
    cand_y  = step_y(cur_y_q, dir_q);
    at_goal = (cur_x_q == X_MAX) && (cur_y_q == Y_MAX);

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          cur_x_d = '0;
          cur_y_d = '0;
          dir_d   = 2'd0;
          sp_d    = '0;
          rp_d    = '0;
          state_d = S_CHK;
        end else begin
          state_d = state_q;
        end
      end
      S_CHK: state_d = S_CHK_W;
      S_CHK_W: begin
        if (mem_rdata) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_MARK;
        end
      end
      S_MARK: begin
        if (at_goal) begin
          rp_d    = '0;
          state_d = S_REPLAY;
        end else begin
          dir_d   = 2'd0;
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        if (cand_ok) begin
          state_d = S_PROBE_W;
        end else if (dir_q != 2'd3) begin
          dir_d = dir_q + 2'd1;
        end else begin
          state_d = S_BACK;
        end
      end
      S_PROBE_W: begin
        if (!mem_rdata) begin
          push_en = 1'b1;
          sp_d    = sp_q + PW'(1);
          cur_x_d = cand_x;
          cur_y_d = cand_y;
          state_d = S_MARK;
        end else if (dir_q != 2'd3) begin
          dir_d   = dir_q + 2'd1;
          state_d = S_PROBE;
        end else begin
          state_d = S_BACK;
        end
      end
      S_BACK: begin
        if (sp_q == '0) begin
          state_d = S_FAIL;
        end else begin
          // Opposite direction is the code with bit 1 flipped.
          sp_d    = sp_m1;
          cur_x_d = step_x(cur_x_q, top_dir ^ 2'd2);
          cur_y_d = step_y(cur_y_q, top_dir ^ 2'd2);
          if (top_dir != 2'd3) begin
            dir_d   = top_dir + 2'd1;
            state_d = S_PROBE;
          end else begin
            state_d = S_BACK;
          end
        end
      end
      S_REPLAY: begin
        if (move_valid_q && move_ready) begin
          rp_d = rp_q + PW'(1);
          if (rp_q == sp_m1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REPLAY;
          end
        end else begin
          rp_d = rp_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are a function of the upcoming state so that they land registered
    // in the same cycle the state is entered.
    nxt_ok       = in_bounds(cur_x_d, cur_y_d, dir_d);
    mem_rd_d     = (state_d == S_CHK) || ((state_d == S_PROBE) && nxt_ok);
    mem_wr_d     = (state_d == S_MARK);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_FAIL);
    done_d       = (state_d == S_DONE);
    fail_d       = (state_d == S_FAIL);
    move_valid_d = (state_d == S_REPLAY);
    if (state_d == S_REPLAY) begin
      move_dir_d = stack_q[rp_d];
    end else begin
      move_dir_d = 2'd0;
    end
    if ((state_d == S_PROBE) && nxt_ok) begin
      addr_x_d = step_x(cur_x_d, dir_d);
      addr_y_d = step_y(cur_y_d, dir_d);
    end else if ((state_d == S_CHK) || (state_d == S_MARK)) begin
      addr_x_d = cur_x_d;
      addr_y_d = cur_y_d;
    end else begin
      addr_x_d = '0;
      addr_y_d = '0;
    end
  end

  // State, search registers, move stack and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      dir_q        <= 2'd0;
      sp_q         <= '0;
      rp_q         <= '0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      addr_x_q     <= '0;
      addr_y_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      move_valid_q <= 1'b0;
      move_dir_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      dir_q        <= dir_d;
      sp_q         <= sp_d;
      rp_q         <= rp_d;
      mem_wr_q     <= mem_wr_d;
      mem_rd_q     <= mem_rd_d;
      addr_x_q     <= addr_x_d;
      addr_y_q     <= addr_y_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      move_valid_q <= move_valid_d;
      move_dir_q   <= move_dir_d;
      if (push_en) begin
        stack_q[sp_q] <= dir_q;
      end
    end
  end

  assign mem_wr     = mem_wr_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr_x = addr_x_q;
  assign mem_addr_y = addr_y_q;
  assign mem_wdata  = mem_wr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign path_len   = sp_q;
  assign move_valid = move_valid_q;
  assign move_dir   = move_dir_q;

endmodule
